// File: rtl/cache_controller_4way_if.sv
// CPU load/store port and word-serial memory refill port of the 4-way cache controller.
// The slave modport is the controller's view of the bus; the master modport is the CPU/memory side.
interface cache_controller_4way_if #(
  parameter int ADR_WIDTH     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WORD_OFFSET   = 2,
  parameter int DATAMEM_WIDTH = DATA_WIDTH << WORD_OFFSET
);
  logic                     req_cpu2cc;
  logic [ADR_WIDTH-1:0]     adr_cpu2cc;
  logic [DATA_WIDTH-1:0]    dat_cpu2cc;
  logic                     rdwr_cpu2cc;
  logic                     ack_cc2cpu;
  logic [DATA_WIDTH-1:0]    dat_cc2cpu;
  logic                     req_cc2mem;
  logic [ADR_WIDTH-1:0]     adr_cc2mem;
  logic                     ack_mem2cc;
  logic [DATA_WIDTH-1:0]    dat_mem2cc;
  logic [DATA_WIDTH-1:0]    dat_mem2mshr;
  logic [WORD_OFFSET-1:0]   word_mem2mshr;
  logic [DATAMEM_WIDTH-1:0] dat_cc2mshr;

  modport slave (
    input  req_cpu2cc, adr_cpu2cc, dat_cpu2cc, rdwr_cpu2cc, ack_mem2cc, dat_mem2cc,
    output ack_cc2cpu, dat_cc2cpu, req_cc2mem, adr_cc2mem, dat_mem2mshr, word_mem2mshr, dat_cc2mshr
  );

  modport master (
    output req_cpu2cc, adr_cpu2cc, dat_cpu2cc, rdwr_cpu2cc, ack_mem2cc, dat_mem2cc,
    input  ack_cc2cpu, dat_cc2cpu, req_cc2mem, adr_cc2mem, dat_mem2mshr, word_mem2mshr, dat_cc2mshr
  );
endinterface

// File: rtl/cache_controller_4way.sv
// Blocking 4-way set-associative data cache with LRU replacement and 4-beat line refill.
// Stores stay in the cache only (write-allocate, no write-back path).
module cache_controller_4way #(
  parameter int ADR_WIDTH     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WORD_OFFSET   = 2,
  parameter int DATAMEM_WIDTH = DATA_WIDTH << WORD_OFFSET,
  parameter int INDEX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_controller_4way_if.slave bus
);
  localparam int WAYS      = 4;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int LINE_LSB  = BYTE_BITS + WORD_OFFSET;
  localparam int TAG_WIDTH = ADR_WIDTH - INDEX_WIDTH - LINE_LSB;
  // Per-way 2-bit ages packed per set; way0=3 (oldest) .. way3=0.
  localparam logic [7:0] AGE_INIT = 8'b00_01_10_11;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, RELEASE} state_t;

  state_t                   state_q, state_d;
  logic [ADR_WIDTH-1:0]     adr_q, adr_d;
  logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
  logic                     rdwr_q, rdwr_d;
  logic [1:0]               way_q, way_d;
  logic [WORD_OFFSET-1:0]   beat_q, beat_d;
  logic                     ack_q, ack_d;
  logic [DATA_WIDTH-1:0]    rdat_q, rdat_d;
  logic                     mreq_q, mreq_d;
  logic [ADR_WIDTH-1:0]     madr_q, madr_d;
  logic [DATA_WIDTH-1:0]    mdat_q, mdat_d;
  logic [WORD_OFFSET-1:0]   mword_q, mword_d;
  logic [DATAMEM_WIDTH-1:0] mline_q, mline_d;
  logic [WAYS-1:0]          valid_q [SETS];
  logic [WAYS-1:0]          valid_d [SETS];
  logic [7:0]               age_q [SETS];
  logic [7:0]               age_d [SETS];

  logic [TAG_WIDTH-1:0]     tag_ram  [SETS][WAYS];
  logic [DATAMEM_WIDTH-1:0] line_ram [SETS][WAYS];

  logic [INDEX_WIDTH-1:0]   idx;
  logic [TAG_WIDTH-1:0]     tag;
  logic [WORD_OFFSET-1:0]   word;
  logic [WAYS-1:0]          hit_vec;
  logic [1:0]               hit_way, victim;
  logic [DATAMEM_WIDTH-1:0] rd_line;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     tag_we, line_we;
  logic [WORD_OFFSET-1:0]   line_word;
  logic [DATA_WIDTH-1:0]    line_wdat;
  logic                     unused_byte_bits;

  assign idx     = adr_q[LINE_LSB +: INDEX_WIDTH];
  assign tag     = adr_q[ADR_WIDTH-1 -: TAG_WIDTH];
  assign word    = adr_q[BYTE_BITS +: WORD_OFFSET];
  assign rd_line = line_ram[idx][way_q];
  assign rd_word = rd_line[word*DATA_WIDTH +: DATA_WIDTH];
  // Accesses are whole words, so the byte lane bits carry no information.
  assign unused_byte_bits = ^adr_q[BYTE_BITS-1:0];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign hit_vec[gi] = valid_q[idx][gi] && (tag_ram[idx][gi] == tag);
  end

  function automatic logic [7:0] lru_touch(input logic [7:0] ages, input logic [1:0] w);
    logic [1:0] aw;
    aw = ages[2*w +: 2];
    lru_touch = ages;
    for (int i = 0; i < WAYS; i++) begin
      if (i == int'(w))              lru_touch[2*i +: 2] = 2'd0;
      else if (ages[2*i +: 2] < aw)  lru_touch[2*i +: 2] = ages[2*i +: 2] + 2'd1;
    end
  endfunction

  // Descending scans let the lowest-numbered way win; an invalid way beats the oldest.
  always_comb begin
    hit_way = 2'd0;
    victim  = 2'd0;
    for (int w = WAYS-1; w >= 0; w--) if (hit_vec[w]) hit_way = w[1:0];
    for (int w = WAYS-1; w >= 0; w--) if (age_q[idx][2*w +: 2] == 2'd3) victim = w[1:0];
    for (int w = WAYS-1; w >= 0; w--) if (!valid_q[idx][w]) victim = w[1:0];
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdwr_d    = rdwr_q;
    way_d     = way_q;
    beat_d    = beat_q;
    ack_d     = 1'b0;
    rdat_d    = rdat_q;
    mreq_d    = mreq_q;
    madr_d    = madr_q;
    mdat_d    = mdat_q;
    mword_d   = mword_q;
    mline_d   = mline_q;
    valid_d   = valid_q;
    age_d     = age_q;
    tag_we    = 1'b0;
    line_we   = 1'b0;
    line_word = beat_q;
    line_wdat = bus.dat_mem2cc;
    case (state_q)
      IDLE: if (bus.req_cpu2cc) begin
        adr_d   = bus.adr_cpu2cc;
        wdat_d  = bus.dat_cpu2cc;
        rdwr_d  = bus.rdwr_cpu2cc;
        state_d = LOOKUP;
      end
      LOOKUP: if (|hit_vec) begin
        way_d      = hit_way;
        age_d[idx] = lru_touch(age_q[idx], hit_way);
        state_d    = RESPOND;
      end else begin
        // The victim is invalidated up front so a partially refilled line can never hit.
        way_d               = victim;
        valid_d[idx][victim] = 1'b0;
        beat_d              = '0;
        mreq_d              = 1'b1;
        madr_d              = {tag, idx, {LINE_LSB{1'b0}}};
        state_d             = REFILL;
      end
      REFILL: if (bus.ack_mem2cc) begin
        line_we = 1'b1;
        mdat_d  = bus.dat_mem2cc;
        mword_d = beat_q;
        mline_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = bus.dat_mem2cc;
        beat_d  = beat_q + 1'b1;
        if (&beat_q) begin
          mreq_d              = 1'b0;
          tag_we              = 1'b1;
          valid_d[idx][way_q] = 1'b1;
          age_d[idx]          = lru_touch(age_q[idx], way_q);
          state_d             = RESPOND;
        end
      end
      RESPOND: begin
        ack_d = 1'b1;
        if (rdwr_q) begin
          line_we   = 1'b1;
          line_word = word;
          line_wdat = wdat_q;
        end else begin
          rdat_d = rd_word;
        end
        state_d = RELEASE;
      end
      RELEASE: if (!bus.req_cpu2cc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdwr_q  <= 1'b0;
      way_q   <= '0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      mreq_q  <= 1'b0;
      madr_q  <= '0;
      mdat_q  <= '0;
      mword_q <= '0;
      mline_q <= '0;
      valid_q <= '{default: '0};
      age_q   <= '{default: AGE_INIT};
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdwr_q  <= rdwr_d;
      way_q   <= way_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      mreq_q  <= mreq_d;
      madr_q  <= madr_d;
      mdat_q  <= mdat_d;
      mword_q <= mword_d;
      mline_q <= mline_d;
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Tag and line storage need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (tag_we)  tag_ram[idx][way_q] <= tag;
    if (line_we) line_ram[idx][way_q][line_word*DATA_WIDTH +: DATA_WIDTH] <= line_wdat;
  end

  assign bus.ack_cc2cpu    = ack_q;
  assign bus.dat_cc2cpu    = rdat_q;
  assign bus.req_cc2mem    = mreq_q;
  assign bus.adr_cc2mem    = madr_q;
  assign bus.dat_mem2mshr  = mdat_q;
  assign bus.word_mem2mshr = mword_q;
  assign bus.dat_cc2mshr   = mline_q;
endmodule

// File: tb/tb_cache_controller_4way.sv
// Self-checking bench for cache_controller_4way: directed vector table, hand-written
// corner sequences and randomized traffic against a recency-list cache model.
module tb_cache_controller_4way;
  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  cache_controller_4way_if bus ();
  cache_controller_4way dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic ones_mode = 1'b1;
  logic gaps_en   = 1'b0;
  logic junk_en   = 1'b0;
  logic [31:0] last_rd = '0;

  // Reference model: per set, valid/tag/words plus a recency list (index 0 = most recent).
  logic        m_valid [16][4];
  logic [23:0] m_tag   [16][4];
  logic [31:0] m_data  [16][4][4];
  int          m_order [16][4];

  function automatic logic [31:0] mem_word(input logic [31:0] la, input int k);
    if (ones_mode) return 32'hFFFF_FFFF;
    return ((la + 32'(k * 4)) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_order[s][w] = 3 - w;
      end
  endtask

  task automatic model_touch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endtask

  task automatic model_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              output logic miss, output logic [31:0] rd);
    int s, wi, way;
    logic [23:0] t;
    s = int'(a[7:4]); wi = int'(a[3:2]); t = a[31:8]; way = -1; rd = '0;
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    miss = (way < 0);
    if (miss) begin
      for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) way = m_order[s][3];
      for (int k = 0; k < 4; k++) m_data[s][way][k] = mem_word({a[31:4], 4'b0}, k);
      m_valid[s][way] = 1'b1;
      m_tag[s][way]   = t;
    end
    model_touch(s, way);
    if (wr) m_data[s][way][wi] = wd;
    else    rd = m_data[s][way][wi];
  endtask

  // Memory responder: one beat per strobe, optional gaps, junk strobes while no refill is pending.
  int beat_cnt = 0;
  initial begin
    bus.ack_mem2cc = 1'b0;
    bus.dat_mem2cc = '0;
    forever begin
      @(posedge clk); #1;
      bus.ack_mem2cc = 1'b0;
      if (!bus.req_cc2mem) begin
        beat_cnt = 0;
        if (junk_en && $urandom_range(0, 3) == 0) begin
          bus.ack_mem2cc = 1'b1;
          bus.dat_mem2cc = $urandom;
        end
      end else if (beat_cnt < 4 && (!gaps_en || $urandom_range(0, 2) != 0)) begin
        bus.ack_mem2cc = 1'b1;
        bus.dat_mem2cc = mem_word(bus.adr_cc2mem, beat_cnt);
        beat_cnt++;
      end
    end
  end

  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic miss, output int ack_n, output int b4_n,
                        output logic [31:0] madr, output logic [127:0] mline, output int acks);
    int beats;
    bus.req_cpu2cc = 1'b1; bus.adr_cpu2cc = a; bus.dat_cpu2cc = wd; bus.rdwr_cpu2cc = wr;
    miss = 1'b0; ack_n = -1; b4_n = -1; madr = '0; mline = '0; acks = 0; beats = 0; rd = '0;
    for (int n = 1; n <= 200 && ack_n < 0; n++) begin
      @(posedge clk); #2;
      if (bus.req_cc2mem) begin miss = 1'b1; madr = bus.adr_cc2mem; end
      if (bus.req_cc2mem && bus.ack_mem2cc) begin
        beats++;
        if (beats == 4) b4_n = n;
      end
      if (bus.ack_cc2cpu) begin
        ack_n = n; rd = bus.dat_cc2cpu; mline = bus.dat_cc2mshr; acks = 1;
      end
    end
    repeat (hold) begin @(posedge clk); #2; if (bus.ack_cc2cpu) acks++; end
    bus.req_cpu2cc = 1'b0;
    repeat (2) begin @(posedge clk); #2; if (bus.ack_cc2cpu) acks++; end
  endtask

  task automatic run_txn(input string name, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int hold, input logic has_tab, input logic tab_miss, input logic [31:0] tab_rd);
    logic m_miss, e_miss, miss;
    logic [31:0] m_rd, e_rd, rd, madr, la;
    logic [127:0] mline, e_line;
    int ack_n, b4_n, acks;
    model_access(wr, a, wd, m_miss, m_rd);
    e_miss = has_tab ? tab_miss : m_miss;
    e_rd   = wr ? last_rd : (has_tab ? tab_rd : m_rd);
    la     = {a[31:4], 4'b0};
    do_txn(wr, a, wd, hold, rd, miss, ack_n, b4_n, madr, mline, acks);
    $display("txn %s wr=%0d adr=%h wdat=%h rd=%h miss=%0d ack_cycle=%0d", name, wr, a, wd, rd, miss, ack_n);
    check({name, " ack_seen"}, (ack_n > 0) ? 1 : 0, 1);
    check({name, " ack_count"}, acks, 1);
    check({name, " miss"}, miss, e_miss);
    check({name, " dat_cc2cpu"}, rd, e_rd);
    if (e_miss) begin
      for (int k = 0; k < 4; k++) e_line[32*k +: 32] = mem_word(la, k);
      check({name, " adr_cc2mem"}, madr, la);
      check({name, " miss_latency"}, ack_n, b4_n + 2);
      check({name, " dat_cc2mshr"}, mline, e_line);
      check({name, " word_mem2mshr"}, bus.word_mem2mshr, 2'd3);
      check({name, " dat_mem2mshr"}, bus.dat_mem2mshr, mem_word(la, 3));
    end else begin
      check({name, " hit_latency"}, ack_n - 1, 2);
    end
    if (!wr) last_rd = e_rd;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        exp_miss;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int beats;
    bus.req_cpu2cc = 1'b0; bus.adr_cpu2cc = '0; bus.dat_cpu2cc = '0; bus.rdwr_cpu2cc = 1'b0;

    vecs[0]  = '{1'b0, 32'hFF07BD08, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[1]  = '{1'b0, 32'hA5552D0C, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[2]  = '{1'b0, 32'hD500AD00, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[3]  = '{1'b0, 32'hFFFFFD08, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[4]  = '{1'b0, 32'hFF07BD00, 32'h0,        1'b0, 32'hFFFFFFFF};
    vecs[5]  = '{1'b1, 32'hFFFFFD08, 32'h55455552, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'hA5552D08, 32'hAA8AAAA4, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'hAFD52D08, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[8]  = '{1'b0, 32'hA5552D08, 32'h0,        1'b0, 32'hAA8AAAA4};
    vecs[9]  = '{1'b1, 32'hA5552D00, 32'h11111111, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'hA5552D04, 32'h22222222, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'hA5552D0C, 32'h33333333, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'hA5552D00, 32'h0,        1'b0, 32'h11111111};
    vecs[13] = '{1'b0, 32'hA5552D04, 32'h0,        1'b0, 32'h22222222};
    vecs[14] = '{1'b0, 32'hA5552D0C, 32'h0,        1'b0, 32'h33333333};
    vecs[15] = '{1'b0, 32'hFFFFFD08, 32'h0,        1'b0, 32'h55455552};
    vecs[16] = '{1'b0, 32'hD500AD00, 32'h0,        1'b1, 32'hFFFFFFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset ack_cc2cpu", bus.ack_cc2cpu, 0);
    check("reset dat_cc2cpu", bus.dat_cc2cpu, 0);
    check("reset req_cc2mem", bus.req_cc2mem, 0);
    check("reset adr_cc2mem", bus.adr_cc2mem, 0);
    check("reset dat_mem2mshr", bus.dat_mem2mshr, 0);
    check("reset word_mem2mshr", bus.word_mem2mshr, 0);
    check("reset dat_cc2mshr", bus.dat_cc2mshr, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #2;

    // Directed table
    for (int i = 0; i < 17; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].wdat, 0,
              1'b1, vecs[i].exp_miss, vecs[i].exp_rd);

    // Request held three cycles past ack: must be serviced once
    run_txn("hold", 1'b0, 32'hA5552D00, 32'h0, 3, 1'b1, 1'b0, 32'h11111111);

    // Reset in the middle of a refill
    bus.req_cpu2cc = 1'b1; bus.adr_cpu2cc = 32'h1234_5670; bus.rdwr_cpu2cc = 1'b0;
    beats = 0;
    for (int n = 0; n < 60 && beats < 2; n++) begin
      @(posedge clk); #2;
      if (bus.req_cc2mem && bus.ack_mem2cc) beats++;
    end
    check("abort beats_reached", beats, 2);
    check("abort req_before", bus.req_cc2mem, 1);
    #1 rst = 1'b0;
    #1;
    check("abort ack_cc2cpu", bus.ack_cc2cpu, 0);
    check("abort dat_cc2cpu", bus.dat_cc2cpu, 0);
    check("abort req_cc2mem", bus.req_cc2mem, 0);
    check("abort adr_cc2mem", bus.adr_cc2mem, 0);
    check("abort dat_mem2mshr", bus.dat_mem2mshr, 0);
    check("abort word_mem2mshr", bus.word_mem2mshr, 0);
    check("abort dat_cc2mshr", bus.dat_cc2mshr, 0);
    bus.req_cpu2cc = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    last_rd = '0;
    @(posedge clk); #2;
    run_txn("abort_reread", 1'b0, 32'h1234_5670, 32'h0, 0, 1'b1, 1'b1, 32'hFFFFFFFF);
    run_txn("abort_cleared", 1'b0, 32'hA5552D08, 32'h0, 0, 1'b1, 1'b1, 32'hFFFFFFFF);

    // Randomized traffic against the model
    ones_mode = 1'b0;
    gaps_en   = 1'b1;
    junk_en   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a[31:8] = 24'hABC000 + 24'($urandom_range(0, 5));
      a[7:4]  = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd9;
      a[3:2]  = 2'($urandom_range(0, 3));
      a[1:0]  = 2'($urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
              $urandom_range(0, 2), 1'b0, 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_controller_4way.md
Name: cache_controller_4way

Overview:
- Blocking 4-way set-associative data cache controller between the CPU load/store port and a word-serial memory refill port.
- Tag/data/valid/LRU state is held in internal registers.
- Misses trigger a 4-beat line refill; each beat is mirrored to an MSHR side-port together with the assembled line.
- One outstanding request at a time.

Parameters:
- ADR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, CPU and memory word width.
- WORD_OFFSET, 2, word-in-line index bits (4 words per line).
- DATAMEM_WIDTH, 128, line width (DATA_WIDTH << WORD_OFFSET).
- INDEX_WIDTH, 4, set index bits (16 sets). Associativity is fixed at 4 ways.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_cpu2cc  in  1  CPU request; held until ack, then dropped.
- adr_cpu2cc  in  ADR_WIDTH  byte address.
- dat_cpu2cc  in  DATA_WIDTH  store data.
- rdwr_cpu2cc  in  1  0 = read, 1 = write.
- ack_cc2cpu  out  1  one-cycle completion pulse.
- dat_cc2cpu  out  DATA_WIDTH  read data, valid with ack and held afterwards.
- req_cc2mem  out  1  refill request.
- adr_cc2mem  out  ADR_WIDTH  line-aligned refill address.
- ack_mem2cc  in  1  one-cycle beat strobe.
- dat_mem2cc  in  DATA_WIDTH  beat data, valid with ack_mem2cc.
- dat_mem2mshr  out  DATA_WIDTH  last received beat.
- word_mem2mshr  out  WORD_OFFSET  word index of last beat.
- dat_cc2mshr  out  DATAMEM_WIDTH  line assembly buffer.

Behaviour:
- Address split: [1:0] byte (ignored), [3:2] word, [7:4] index, [31:8] tag (24 bits).
- Reset (rst=0, async): all valid bits cleared; LRU ages per set initialised to way0=3, way1=2, way2=1, way3=0; FSM to IDLE; every output 0.
- FSM states: IDLE, LOOKUP, REFILL, RESPOND, RELEASE.
- IDLE: on req_cpu2cc=1, register adr/dat/rdwr and go to LOOKUP.
- LOOKUP: compare the tag against the 4 valid ways of the set.
  - Hit: go to RESPOND.
  - Miss: select victim, assert req_cc2mem with adr_cc2mem = {tag, index, 4'b0}, go to REFILL.
- Victim selection: lowest-numbered invalid way; if all ways are valid, the way whose age == 3.
- REFILL:
  - Beats arrive in order word 0..3; a beat counter advances only on ack_mem2cc.
  - Each beat: write the word into the victim line and the assembly buffer; update dat_mem2mshr and word_mem2mshr.
  - On the 4th beat: drop req_cc2mem the next cycle, write the tag, set valid, go to RESPOND.
  - ack_mem2cc outside REFILL is ignored.
- RESPOND:
  - ack_cc2cpu=1 for exactly one cycle.
  - Read: dat_cc2cpu = selected word.
  - Write: selected word := dat_cpu2cc; dat_cc2cpu is unchanged. Write-allocate: a write miss refills first, then merges.
  - No memory write path; stores are held only in the cache.
- LRU update on every hit or fill of way w: ways with age < age[w] increment; age[w] := 0.
- RELEASE: wait for req_cpu2cc=0, then go to IDLE. A request held high past ack is never serviced twice.
- Latency:
  - Hit: ack 2 cycles after the request is sampled in IDLE.
  - Miss: ack 1 cycle after the cycle following the 4th beat.
- Reset asserted mid-refill aborts immediately; the partial line stays invalid.

Test Plan:
- Read misses to 0xFF07BD08, 0xA5552D0C, 0xD500AD00, 0xFFFFFD08 (all set 0):
  - Each raises req_cc2mem with adr 0x...D00 and takes 4 beats of 0xFFFFFFFF.
  - Each returns ack with dat_cc2cpu = 0xFFFFFFFF.
  - Lines fill ways 0,1,2,3 in that order.
- Read 0xFF07BD00 -> hit way0: no req_cc2mem, ack 2 cycles after sampling, data 0xFFFFFFFF.
- Write 0x55455552 to 0xFFFFFD08 (way3), then write 0xAA8AAAA4 to 0xA5552D08 (way1) -> both are hits with no memory request.
- Read miss 0xAFD52D08:
  - Evicts way2 (LRU).
  - Subsequent read of 0xA5552D08 hits and returns 0xAA8AAAA4.
- Writes to 0xA5552D00, 0xA5552D04, 0xA5552D0C -> hits; read-backs return the written words.
- Hold req_cpu2cc 3 cycles past ack -> exactly one ack; assert rst=0 mid-refill -> outputs 0 and the line is invalid (a re-read misses).
